fetch_pc_unit: RTL
==================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC width in bits, minimum 8.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_3000: PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_4180: exception handler entry address.
REQ-004 SHALL have parameter INC, default 4: sequential PC increment in bytes.
REQ-005 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port stall_i  in  1  fetch stall; PC holds while high.
REQ-008 SHALL have port br_valid_i  in  1  branch/jump redirect request from decode.
REQ-009 SHALL have port br_target_i  in  WIDTH  branch/jump target address.
REQ-010 SHALL have port exc_valid_i  in  1  exception redirect request (present only with FETCH_PC_EXC_EN).
REQ-011 SHALL have port eret_valid_i  in  1  return-from-exception request (present only with FETCH_PC_EXC_EN).
REQ-012 SHALL have port epc_i  in  WIDTH  ERET return address (present only with FETCH_PC_EXC_EN).
REQ-013 SHALL have port pc_o  out  WIDTH  current fetch PC, registered.
REQ-014 SHALL have port pc_plus_o  out  WIDTH  pc_o + INC, combinational.
REQ-015 SHALL have port misalign_o  out  1  high when pc_o[1:0] != 0.
REQ-016 SHALL have port pend_o  out  1  high while a deferred branch redirect is held.

Function
REQ-017 SHALL compute next PC with priority exc_valid_i > eret_valid_i > br_valid_i > pending branch > pc_o + INC.
REQ-018 SHALL load EXC_VECTOR on exc_valid_i, or epc_i on eret_valid_i, at the next edge regardless of stall_i.
REQ-019 SHALL clear the pending branch on any exception or ERET redirect.
REQ-020 SHALL, when stall_i=0 and br_valid_i=1, load br_target_i at the next edge; one-cycle latency.
REQ-021 SHALL, when stall_i=1 and br_valid_i=1, hold pc_o and capture br_target_i in the pending register; pend_o=1 from the next cycle.
REQ-022 SHALL overwrite an existing pending target when a newer br_valid_i arrives during stall; newest wins.
REQ-023 SHALL, on the first cycle with stall_i=0 and pend_o=1, load the pending target and clear pend_o at the same edge.
REQ-024 SHALL give a fresh br_valid_i priority over the pending target when both apply with stall_i=0; pending cleared.
REQ-025 SHALL hold pc_o unchanged when stall_i=1 and no exception/ERET is requested.
REQ-026 SHALL compute pc_o + INC modulo 2^WIDTH; all-ones region wraps to low addresses without error.
REQ-027 SHALL derive misalign_o purely from pc_o; misaligned targets are loaded unchanged, never corrected.

Reset
REQ-028 SHALL, while reset=1, set pc_o=RESET_VECTOR, pend_o=0, pending target=0 at the edge, overriding all requests.
REQ-029 SHALL, on reset asserted mid-stall with a pending branch, discard that branch; first post-reset fetch is RESET_VECTOR, then RESET_VECTOR+INC.

Configuration
REQ-030 SHALL compile exception/ERET support only when macro FETCH_PC_EXC_EN is defined.
REQ-031 SHALL, without FETCH_PC_EXC_EN, omit exc_valid_i, eret_valid_i, epc_i and EXC_VECTOR logic; priority becomes branch > pending > increment.

Structure
REQ-032 SHALL take default RESET_VECTOR, EXC_VECTOR, INC and the redirect-source enum (NONE, SEQ, BR, PEND, EXC, ERET) from shared package fetch_pkg.
REQ-033 SHALL implement the pending register and its capture/clear logic as sub-module pc_redirect_latch.

Verification
REQ-034 Reset 1 cycle, no stall, 3 cycles -> pc_o = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-035 pc_o=0x3010, stall_i=1 and br_valid_i=1 target 0x3400 for 1 cycle, stall 2 more cycles -> pc_o holds 0x3010, pend_o=1; stall drops -> next pc_o=0x3400, pend_o=0.
REQ-036 Pending 0x3400, stall drops with br_valid_i=1 target 0x3800 -> pc_o=0x3800, pend_o=0.
REQ-037 FETCH_PC_EXC_EN: stall_i=1, pending 0x3400, exc_valid_i=1 -> pc_o=0x4180, pend_o=0; then eret_valid_i=1, epc_i=0x3020 -> pc_o=0x3020.
REQ-038 pc_o=0xFFFF_FFFC, no stall -> pc_o=0x0000_0000; br_target_i=0x3002 -> misalign_o=1 with pc_o=0x3002.
REQ-039 Reset asserted during stall with pending 0x3400 -> pc_o=0x3000, pend_o=0; after release, no jump to 0x3400.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default vectors, sequential increment and
// the redirect-source encoding used to select the next PC.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_3000;
    localparam logic [31:0] FETCH_EXC_VECTOR   = 32'h0000_4180;
    localparam int unsigned FETCH_INC          = 4;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_SEQ,
        SRC_BR,
        SRC_PEND,
        SRC_EXC,
        SRC_ERET
    } redirect_src_e;

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a branch redirect that arrived while fetch was stalled so it can be
// applied on the first unstalled cycle.
module pc_redirect_latch
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             br_valid_i,
    input  logic [WIDTH-1:0] br_target_i,
    input  logic             flush_i,
    output logic             pend_o,
    output logic [WIDTH-1:0] pend_target_o
);

    logic             pend_d, pend_q;
    logic [WIDTH-1:0] target_d, target_q;

    always_comb begin
        pend_d   = pend_q;
        target_d = target_q;
        if (flush_i) begin
            pend_d = 1'b0;
        end else if (stall_i) begin
            if (br_valid_i) begin
                pend_d   = 1'b1;
                target_d = br_target_i;
            end
        end else begin
            // Unstalled: the entry is either consumed now or superseded by a fresh branch.
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q   <= 1'b0;
            target_q <= '0;
        end else begin
            pend_q   <= pend_d;
            target_q <= target_d;
        end
    end

    assign pend_o        = pend_q;
    assign pend_target_o = target_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch program counter with stall-deferred branch redirects.
// Exception/ERET redirects are built only when FETCH_PC_EXC_EN is defined.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(FETCH_RESET_VECTOR),
    parameter int unsigned      INC          = FETCH_INC
`ifdef FETCH_PC_EXC_EN
    ,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(FETCH_EXC_VECTOR)
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             br_valid_i,
    input  logic [WIDTH-1:0] br_target_i,
`ifdef FETCH_PC_EXC_EN
    input  logic             exc_valid_i,
    input  logic             eret_valid_i,
    input  logic [WIDTH-1:0] epc_i,
`endif
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus_o,
    output logic             misalign_o,
    output logic             pend_o
);

    logic [WIDTH-1:0] pc_d, pc_q;
    logic [WIDTH-1:0] pend_target;
    logic             pend;
    logic             flush;
    redirect_src_e    src;

`ifdef FETCH_PC_EXC_EN
    assign flush = exc_valid_i | eret_valid_i;
`else
    assign flush = 1'b0;
`endif

    pc_redirect_latch #(
        .WIDTH(WIDTH)
    ) u_redirect_latch (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .br_valid_i   (br_valid_i),
        .br_target_i  (br_target_i),
        .flush_i      (flush),
        .pend_o       (pend),
        .pend_target_o(pend_target)
    );

    always_comb begin
        src = SRC_SEQ;
`ifdef FETCH_PC_EXC_EN
        if (exc_valid_i) begin
            src = SRC_EXC;
        end else if (eret_valid_i) begin
            src = SRC_ERET;
        end else
`endif
        if (stall_i) begin
            src = SRC_NONE;
        end else if (br_valid_i) begin
            src = SRC_BR;
        end else if (pend) begin
            src = SRC_PEND;
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (src)
            SRC_SEQ:  pc_d = pc_plus_o;
            SRC_BR:   pc_d = br_target_i;
            SRC_PEND: pc_d = pend_target;
`ifdef FETCH_PC_EXC_EN
            SRC_EXC:  pc_d = EXC_VECTOR;
            SRC_ERET: pc_d = epc_i;
`endif
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus_o  = pc_q + WIDTH'(INC);
    assign misalign_o = |pc_q[1:0];
    assign pend_o     = pend;

endmodule
